// File: rtl/hazard_unit_param.sv
// Load-use / forwarding controller beside ID: tracks rd of downstream instrs, emits bypass selects and stalls.
// Optional build macro ECALL_HAZARD_EN: ECALL reads a7 (rs1) and a0 (rs2) for hazard/forward purposes.
module hazard_unit_param #(
    parameter int NUM_FWD_STAGES  = 2,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16,
    localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_sel_rs1,
    output logic [SEL_W-1:0] fwd_sel_rs2,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } trk_t;

    trk_t        trk [NUM_FWD_STAGES];
    opcode_e     opc;
    logic        writes_rd, is_load, uses_rs1, uses_rs2, enter;
    logic [4:0]  rs1_idx, rs2_idx;
    logic [SEL_W:0] res1, res2;
    logic        unused_fields;

    assign opc           = opcode_e'(id_inst[6:0]);
    assign unused_fields = ^{id_inst[31:25], id_inst[14:12]};

    always_comb begin
        writes_rd = 1'b0;
        is_load   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        rs1_idx   = id_inst[19:15];
        rs2_idx   = id_inst[24:20];
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR:   begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_LOAD:   begin writes_rd = 1'b1; is_load = 1'b1; uses_rs1 = 1'b1; end
            OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_IMM:    begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_OP:     begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_SYSTEM: begin
`ifdef ECALL_HAZARD_EN
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                rs1_idx  = 5'd17;
                rs2_idx  = 5'd10;
`else
                uses_rs1 = 1'b0;
`endif
            end
            default: ;
        endcase
        if (id_inst[11:7] == 5'd0) writes_rd = 1'b0;
    end

    // Youngest matching entry decides; an unready load there hides any older match.
    function automatic logic [SEL_W:0] resolve(input logic used, input logic [4:0] rs);
        logic             found, hz;
        logic [SEL_W-1:0] sel;
        found = 1'b0;
        hz    = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_FWD_STAGES; i++) begin
            if (!found && used && rs != 5'd0 && trk[i].v && trk[i].rd == rs) begin
                found = 1'b1;
                if (trk[i].ld && int'(i) < LOAD_USE_CYCLES) hz = 1'b1;
                else sel = SEL_W'(i + 1);
            end
        end
        return {hz, sel};
    endfunction

    assign res1 = resolve(uses_rs1, rs1_idx);
    assign res2 = resolve(uses_rs2, rs2_idx);

    always_comb begin
        stall       = 1'b0;
        fwd_sel_rs1 = '0;
        fwd_sel_rs2 = '0;
        if (!rst && id_valid && !flush) begin
            stall = res1[SEL_W] | res2[SEL_W];
            if (!stall) begin
                fwd_sel_rs1 = res1[SEL_W-1:0];
                fwd_sel_rs2 = res2[SEL_W-1:0];
            end
        end
    end

    assign enter = id_valid & ~stall & ~flush & writes_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FWD_STAGES; i++) trk[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_FWD_STAGES; i++) trk[i] <= trk[i-1];
            trk[0].v  <= enter;
            trk[0].rd <= enter ? id_inst[11:7] : 5'd0;
            trk[0].ld <= enter & is_load;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Bench for hazard_unit_param: default instance (2 stages, 1 load bubble) and a 3-stage/2-bubble instance.
// Directed vector table, hand sequences for multi-cycle load-use, then random traffic against a history model.
module tb_hazard_unit_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_inst = '0;
    logic        flush = 1'b0;

    logic        stall_a, stall_b;
    logic [1:0]  s1_a, s2_a, s1_b, s2_b;
    logic [15:0] cnt_a, cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_unit_param dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall(stall_a), .fwd_sel_rs1(s1_a), .fwd_sel_rs2(s2_a), .stall_cnt(cnt_a)
    );

    hazard_unit_param #(.NUM_FWD_STAGES(3), .LOAD_USE_CYCLES(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
        .stall(stall_b), .fwd_sel_rs1(s1_b), .fwd_sel_rs2(s2_b), .stall_cnt(cnt_b)
    );

`ifdef ECALL_HAZARD_EN
    localparam int ECALL_SEL = 1;
`else
    localparam int ECALL_SEL = 0;
`endif

    // History model: hist[c][age] is the writer that entered EX 'age' cycles ago.
    typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
    ent_t        hist [2][3];
    int unsigned cnt_m [2];
    bit          exp_st [2];
    int          exp_s1 [2], exp_s2 [2];
    bit          cur_r, cur_v, cur_f;
    bit [31:0]   cur_i;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic void decode(input bit [31:0] ins, output bit u1, output bit u2,
                                   output bit wr, output bit ld, output bit [4:0] r1, output bit [4:0] r2);
        bit [6:0] op;
        op = ins[6:0];
        u1 = op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        u2 = op inside {7'h63, 7'h23, 7'h33};
        ld = (op == 7'h03);
        wr = (op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33}) && ins[11:7] != 5'd0;
        r1 = ins[19:15];
        r2 = ins[24:20];
`ifdef ECALL_HAZARD_EN
        if (op == 7'h73) begin u1 = 1; u2 = 1; r1 = 5'd17; r2 = 5'd10; end
`endif
    endfunction

    // Returns -1 for a load-use hazard, otherwise the bypass select.
    function automatic int lookup(input int c, input bit u, input bit [4:0] r);
        int depth, lu;
        depth = (c == 0) ? 2 : 3;
        lu    = (c == 0) ? 1 : 2;
        if (!u || r == 0) return 0;
        for (int age = 0; age < depth; age++)
            if (hist[c][age].v && hist[c][age].rd == r)
                return (hist[c][age].ld && age < lu) ? -1 : age + 1;
        return 0;
    endfunction

    task automatic apply(input bit r, input bit v, input bit [31:0] ins, input bit f);
        bit u1, u2, wr, ld;
        bit [4:0] r1, r2;
        int a, b;
        @(negedge clk);
        rst = r; id_valid = v; id_inst = ins; flush = f;
        cur_r = r; cur_v = v; cur_i = ins; cur_f = f;
        #2;
        decode(ins, u1, u2, wr, ld, r1, r2);
        for (int c = 0; c < 2; c++) begin
            a = lookup(c, u1, r1);
            b = lookup(c, u2, r2);
            exp_st[c] = !r && v && !f && (a < 0 || b < 0);
            exp_s1[c] = (r || !v || f || exp_st[c]) ? 0 : a;
            exp_s2[c] = (r || !v || f || exp_st[c]) ? 0 : b;
        end
        chk("model_stall_a", int'(stall_a), int'(exp_st[0]));
        chk("model_sel1_a", int'(s1_a), exp_s1[0]);
        chk("model_sel2_a", int'(s2_a), exp_s2[0]);
        chk("model_cnt_a", int'(cnt_a), int'(cnt_m[0]));
        chk("model_stall_b", int'(stall_b), int'(exp_st[1]));
        chk("model_sel1_b", int'(s1_b), exp_s1[1]);
        chk("model_sel2_b", int'(s2_b), exp_s2[1]);
        chk("model_cnt_b", int'(cnt_b), int'(cnt_m[1]));
    endtask

    task automatic tick();
        bit u1, u2, wr, ld;
        bit [4:0] r1, r2;
        @(posedge clk);
        decode(cur_i, u1, u2, wr, ld, r1, r2);
        for (int c = 0; c < 2; c++) begin
            if (cur_r) begin
                for (int k = 0; k < 3; k++) hist[c][k] = '{0, 5'd0, 0};
                cnt_m[c] = 0;
            end else begin
                if (exp_st[c] && cnt_m[c] != 32'hFFFF) cnt_m[c]++;
                hist[c][2] = hist[c][1];
                hist[c][1] = hist[c][0];
                if (cur_v && !exp_st[c] && !cur_f && wr) hist[c][0] = '{1, cur_i[11:7], ld};
                else hist[c][0] = '{0, 5'd0, 0};
            end
        end
    endtask

    function automatic bit [31:0] itype(input int op, input int rd, input int rs1, input int imm);
        bit [6:0] o; bit [4:0] d, s; bit [11:0] im;
        o = 7'(op); d = 5'(rd); s = 5'(rs1); im = 12'(imm);
        return {im, s, 3'b010, d, o};
    endfunction

    function automatic bit [31:0] rtype(input int rd, input int rs1, input int rs2, input bit sub);
        bit [4:0] d, s1, s2;
        d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
        return {1'b0, sub, 5'b0, s2, s1, 3'b000, d, 7'h33};
    endfunction

    function automatic bit [31:0] rand_inst();
        bit [6:0]  ops  [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};
        bit [4:0]  regs [6]  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd10, 5'd17};
        bit [31:0] w;
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 10)];
        w[11:7]  = regs[$urandom_range(0, 5)];
        w[19:15] = regs[$urandom_range(0, 5)];
        w[24:20] = regs[$urandom_range(0, 5)];
        return w;
    endfunction

    typedef struct { bit r; bit v; bit [31:0] ins; bit f; bit st; int s1; int s2; int cnt; } vec_t;
    vec_t tbl [$];

    task automatic add(input bit r, input bit v, input bit [31:0] ins, input bit f,
                       input bit st, input int s1, input int s2, input int cnt);
        tbl.push_back('{r, v, ins, f, st, s1, s2, cnt});
    endtask

    initial begin
        bit [31:0] lw5, use5, ins;
        bit v, f, r;
        for (int c = 0; c < 2; c++) begin
            cnt_m[c] = 0;
            for (int k = 0; k < 3; k++) hist[c][k] = '{0, 5'd0, 0};
        end
        repeat (2) @(posedge clk);

        lw5  = itype(7'h03, 5, 0, 0);
        use5 = rtype(7, 5, 0, 0);
        add(1, 1, rtype(6, 5, 5, 0), 0, 0, 0, 0, 0);
        add(0, 1, itype(7'h13, 5, 0, 1), 0, 0, 0, 0, 0);
        add(0, 1, rtype(6, 5, 5, 0), 0, 0, 1, 1, 0);
        add(0, 1, itype(7'h13, 5, 0, 1), 0, 0, 0, 0, 0);
        add(0, 1, itype(7'h13, 5, 0, 2), 0, 0, 0, 0, 0);
        add(0, 1, rtype(8, 5, 5, 1), 0, 0, 1, 1, 0);
        add(0, 1, lw5, 0, 0, 0, 0, 0);
        add(0, 1, use5, 0, 1, 0, 0, 0);
        add(0, 1, use5, 0, 0, 2, 0, 1);
        add(0, 1, itype(7'h13, 0, 0, 1), 0, 0, 0, 0, 1);
        add(0, 1, rtype(1, 0, 0, 0), 0, 0, 0, 0, 1);
        add(0, 1, lw5, 0, 0, 0, 0, 1);
        add(0, 1, use5, 1, 0, 0, 0, 1);
        add(0, 1, rtype(9, 7, 7, 0), 0, 0, 0, 0, 1);
        add(0, 1, itype(7'h13, 17, 0, 93), 0, 0, 0, 0, 1);
        add(0, 1, 32'h0000_0073, 0, 0, ECALL_SEL, 0, 1);
        add(0, 1, lw5, 0, 0, 0, 0, 1);
        add(1, 1, use5, 0, 0, 0, 0, 1);
        add(0, 1, use5, 0, 0, 0, 0, 0);

        foreach (tbl[k]) begin
            apply(tbl[k].r, tbl[k].v, tbl[k].ins, tbl[k].f);
            chk($sformatf("vec%0d_stall", k), int'(stall_a), int'(tbl[k].st));
            chk($sformatf("vec%0d_sel1", k), int'(s1_a), tbl[k].s1);
            chk($sformatf("vec%0d_sel2", k), int'(s2_a), tbl[k].s2);
            chk($sformatf("vec%0d_cnt", k), int'(cnt_a), tbl[k].cnt);
            tick();
        end

        // Multi-cycle load-use: one bubble on the default build, two on the deep one.
        apply(1, 0, 32'h0, 0); tick();
        apply(0, 1, lw5, 0); tick();
        apply(0, 1, use5, 0);
        chk("lu_c1_stall_a", int'(stall_a), 1);
        chk("lu_c1_stall_b", int'(stall_b), 1);
        tick();
        apply(0, 1, use5, 0);
        chk("lu_c2_stall_a", int'(stall_a), 0);
        chk("lu_c2_sel1_a", int'(s1_a), 2);
        chk("lu_c2_stall_b", int'(stall_b), 1);
        tick();
        apply(0, 1, use5, 0);
        chk("lu_c3_stall_b", int'(stall_b), 0);
        chk("lu_c3_sel1_b", int'(s1_b), 3);
        tick();
        apply(0, 0, 32'h0, 0);
        chk("lu_cnt_a", int'(cnt_a), 1);
        chk("lu_cnt_b", int'(cnt_b), 2);
        tick();

        ins = rand_inst();
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 7) != 0);
            apply(r, v, ins, f);
            tick();
            if (!(exp_st[0] || exp_st[1]) || r || f) ins = rand_inst();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
